// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// FETCH_JUMP_PREDECODE_EN enables the in-fetch J redirect (see fetch_unit_jump_predecoder).
package fetch_unit_pkg;

    localparam logic [5:0]  OP_J              = 6'b000010;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'd0;
    localparam int unsigned DEFAULT_MEM_DEPTH = 128;

    // What the fetch state does at the next edge, in priority order.
    typedef enum logic [2:0] {
        ActRedirect,
        ActStall,
        ActJump,
        ActHalt,
        ActFetch
    } fetch_action_e;

    function automatic logic is_jump(input logic [5:0] opcode);
        return opcode == OP_J;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decode control, instruction memory address/data and decode-facing outputs.
// The predecode_redirect signal is only ever non-zero with FETCH_JUMP_PREDECODE_EN.
interface fetch_unit_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        halted;
    logic        predecode_redirect;

    modport master (
        input  stall, redirect_valid, redirect_target, inst,
        output pc, fetch_valid, fetch_pc, fetch_inst, halted, predecode_redirect
    );

    modport slave (
        output stall, redirect_valid, redirect_target, inst,
        input  pc, fetch_valid, fetch_pc, fetch_inst, halted, predecode_redirect
    );

endinterface

// File: rtl/fetch_unit_jump_predecoder.sv
// Combinational J detector for the in-flight fetch word; target keeps the upper PC bits of pc+1.
// Only compiled in when FETCH_JUMP_PREDECODE_EN is defined.
`ifdef FETCH_JUMP_PREDECODE_EN
module fetch_unit_jump_predecoder
    import fetch_unit_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        is_j_o,
    output logic [31:0] target_o
);

    assign is_j_o = is_jump(inst_i[31:26]);

    // (pc+1)[31:26] is pc[31:26] plus the carry out of the low 26 bits.
    assign target_o = {pc_i[31:26] + {5'b0, &pc_i[25:0]}, inst_i[25:0]};

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, replays on stall, handles redirects and end-of-memory halt.
// Define FETCH_JUMP_PREDECODE_EN to let fetch resolve J instructions itself.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    logic [31:0]   pc_reg_q, pc_reg_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic          halted_q, halted_d;
    logic          jump_hit;
    logic [31:0]   jump_target;
    fetch_action_e action;

`ifdef FETCH_JUMP_PREDECODE_EN
    logic is_j;

    fetch_unit_jump_predecoder u_jump_predecoder (
        .inst_i   (bus.inst),
        .pc_i     (fetch_pc_q),
        .is_j_o   (is_j),
        .target_o (jump_target)
    );

    assign jump_hit = is_j & fetch_valid_q;
`else
    assign jump_hit    = 1'b0;
    assign jump_target = '0;
`endif

    always_comb begin
        if (bus.redirect_valid) begin
            action = ActRedirect;
        end else if (bus.stall) begin
            action = ActStall;
        end else if (jump_hit) begin
            action = ActJump;
        end else if (pc_reg_q >= MEM_DEPTH) begin
            action = ActHalt;
        end else begin
            action = ActFetch;
        end
    end

    always_comb begin
        pc_reg_d      = pc_reg_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        halted_d      = halted_q;
        unique case (action)
            ActRedirect: begin
                pc_reg_d      = bus.redirect_target;
                fetch_valid_d = 1'b0;
                if (bus.redirect_target < MEM_DEPTH) begin
                    halted_d = 1'b0;
                end
            end
            ActStall: begin
            end
            ActJump: begin
                pc_reg_d      = jump_target;
                fetch_valid_d = 1'b0;
            end
            ActHalt: begin
                fetch_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            ActFetch: begin
                fetch_pc_d    = pc_reg_q;
                fetch_valid_d = 1'b1;
                pc_reg_d      = pc_reg_q + 32'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg_q      <= RESET_PC;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_reg_q      <= pc_reg_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
        end
    end

    // A stall re-reads the held word so the memory output stays put.
    always_comb begin
        if (rst) begin
            bus.pc = RESET_PC;
        end else if (bus.stall && !bus.redirect_valid) begin
            bus.pc = fetch_pc_q;
        end else begin
            bus.pc = pc_reg_q;
        end
    end

    assign bus.fetch_valid        = fetch_valid_q;
    assign bus.fetch_pc           = fetch_pc_q;
    assign bus.fetch_inst         = bus.inst;
    assign bus.halted             = halted_q;
    assign bus.predecode_redirect = (action == ActJump) && !rst;

endmodule
